// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter with a registered output stage.
// Define AXIS_RR_ARBITER_TID_EN to add m_axis_tid, the source index of each output beat.
module axis_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic                             m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic                             busy
`ifdef AXIS_RR_ARBITER_TID_EN
  ,
  output logic [SEL_WIDTH-1:0]             m_axis_tid
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1
  } state_t;

  state_t                state, state_next;
  logic [SEL_WIDTH-1:0]  grant, grant_next;
  logic [SEL_WIDTH-1:0]  last_grant, last_grant_next;
  logic [SEL_WIDTH-1:0]  winner, start, cand;
  logic                  found;
  int                    idx;
  logic                  load_en;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  assign load_en = ~m_axis_tvalid | m_axis_tready;
  assign busy    = (state == BUSY);
  assign accept  = |(s_axis_tvalid & s_axis_tready);

  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      s_axis_tready[i] = (state == BUSY) && (grant == SEL_WIDTH'(i)) && load_en;
    end
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        sel_data = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_last = s_axis_tlast[i];
      end
    end
  end

  // Wrap by explicit compare so non-power-of-two sizes never index past NUM_INPUTS-1.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    start  = (last_grant == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : last_grant + 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      idx = int'(start) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      cand = SEL_WIDTH'(idx);
      if (!found && s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_next = winner;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SEL_WIDTH'(NUM_INPUTS - 1);
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (load_en) begin
      if (accept) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= sel_data;
        m_axis_tlast  <= sel_last;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_RR_ARBITER_TID_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tid <= '0;
    end else if (load_en && accept) begin
      m_axis_tid <= grant;
    end
  end
`else
  // Source index is not tracked in this build.
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed self-checking bench for axis_rr_arbiter (4 inputs, 32-bit data).
// Source queues feed the inputs; every output beat is checked against a hand-written list.
module tb_axis_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_tvalid;
  logic [127:0] s_tdata;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
`ifdef AXIS_RR_ARBITER_TID_EN
  logic [1:0]  m_tid;
`endif

  axis_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_valid),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tready (m_ready),
    .busy          (busy)
`ifdef AXIS_RR_ARBITER_TID_EN
    ,
    .m_axis_tid    (m_tid)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] src_data [4][8];
  logic        src_last [4][8];
  int          src_ptr [4];
  int          src_len [4];

  logic [31:0] exp_data [32];
  logic        exp_last [32];
  logic [1:0]  exp_src  [32];
  int          exp_n;
  int          n_out;
  int          out_cyc [32];
  int          cyc;
  int          stalls;
  logic        chk_en;

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        s_tvalid[i] = 1'b1;
        s_tdata[i*32 +: 32] = src_data[i][src_ptr[i]];
        s_tlast[i] = src_last[i][src_ptr[i]];
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*32 +: 32] = 32'h0;
        s_tlast[i] = 1'b0;
      end
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      src_ptr[i] = 0;
      src_len[i] = 0;
    end
    exp_n = 0;
    n_out = 0;
    cyc = 0;
    stalls = 0;
    drive();
  endtask

  task automatic add_beats(input int i, input logic [31:0] base, input int n, input logic end_last);
    for (int k = 0; k < n; k++) begin
      src_data[i][src_len[i]] = base + k;
      src_last[i][src_len[i]] = end_last && (k == n - 1);
      src_len[i]++;
    end
  endtask

  task automatic expect_beats(input int i, input logic [31:0] base, input int n, input logic end_last);
    for (int k = 0; k < n; k++) begin
      exp_data[exp_n] = base + k;
      exp_last[exp_n] = end_last && (k == n - 1);
      exp_src[exp_n]  = 2'(i);
      exp_n++;
    end
  endtask

  task automatic step();
    logic [3:0] fire;
    @(negedge clk);
    fire = s_tvalid & s_tready;
    if (chk_en) begin
      total++;
      if (!$onehot0(s_tready)) begin
        bad++;
        $display("FAIL ready_onehot: got %b, required at most one bit", s_tready);
      end
      if (m_valid && !m_ready) begin
        stalls++;
        total++;
        if (s_tready !== 4'b0000) begin
          bad++;
          $display("FAIL stall_ready: got %b, required 0000", s_tready);
        end
      end
      if (m_valid) begin
        total++;
        if (n_out >= exp_n) begin
          bad++;
          $display("FAIL extra_beat: got data %h, required no beat", m_data);
        end else begin
          if (m_data !== exp_data[n_out] || m_last !== exp_last[n_out]) begin
            bad++;
            $display("FAIL out_beat[%0d]: got %h/%b, required %h/%b",
                     n_out, m_data, m_last, exp_data[n_out], exp_last[n_out]);
          end
`ifdef AXIS_RR_ARBITER_TID_EN
          total++;
          if (m_tid !== exp_src[n_out]) begin
            bad++;
            $display("FAIL out_tid[%0d]: got %0d, required %0d", n_out, m_tid, exp_src[n_out]);
          end
`endif
        end
        if (m_ready && n_out < 32) begin
          out_cyc[n_out] = cyc;
          n_out++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (fire[i]) src_ptr[i]++;
    drive();
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int b;
    b = budget;
    while (n_out < n && b > 0) begin
      step();
      b--;
    end
    for (int k = 0; k < 3; k++) step();
    total++;
    if (n_out !== exp_n) begin
      bad++;
      $display("FAIL %s_count: got %0d beats, required %0d", name, n_out, exp_n);
    end
  endtask

  task automatic wait_src(input string name, input int i, input int n);
    int b;
    b = 50;
    while (src_ptr[i] < n && b > 0) begin
      step();
      b--;
    end
    total++;
    if (src_ptr[i] < n) begin
      bad++;
      $display("FAIL %s_src_wait: got %0d beats taken, required %0d", name, src_ptr[i], n);
    end
  endtask

  task automatic test_reset();
    chk_en = 1'b0;
    reset = 1'b1;
    m_ready = 1'b1;
    clear_all();
    repeat (2) step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (m_valid !== 1'b0 || s_tready !== 4'b0000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got valid=%b ready=%b busy=%b, required 0/0000/0",
                 c, m_valid, s_tready, busy);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_all_inputs();
    clear_all();
    chk_en = 1'b1;
    m_ready = 1'b1;
    add_beats(0, 32'hA0, 3, 1'b1);
    add_beats(1, 32'hB0, 3, 1'b1);
    add_beats(2, 32'hC0, 3, 1'b1);
    add_beats(3, 32'hD0, 3, 1'b1);
    expect_beats(0, 32'hA0, 3, 1'b1);
    expect_beats(1, 32'hB0, 3, 1'b1);
    expect_beats(2, 32'hC0, 3, 1'b1);
    expect_beats(3, 32'hD0, 3, 1'b1);
    drive();
    run_until("all_inputs", 12, 60);
    // Inside a packet beats are back to back; one empty output cycle between packets.
    for (int k = 1; k < 12; k++) begin
      total++;
      if (out_cyc[k] - out_cyc[k-1] !== ((k % 3 == 0) ? 2 : 1)) begin
        bad++;
        $display("FAIL beat_spacing[%0d]: got %0d cycles, required %0d",
                 k, out_cyc[k] - out_cyc[k-1], (k % 3 == 0) ? 2 : 1);
      end
    end
  endtask

  task automatic test_fairness();
    clear_all();
    chk_en = 1'b1;
    m_ready = 1'b1;
    add_beats(2, 32'h22, 1, 1'b1);
    expect_beats(2, 32'h22, 1, 1'b1);
    expect_beats(3, 32'h33, 1, 1'b1);
    expect_beats(1, 32'h11, 1, 1'b1);
    drive();
    wait_src("fairness", 2, 1);
    add_beats(1, 32'h11, 1, 1'b1);
    add_beats(3, 32'h33, 1, 1'b1);
    drive();
    run_until("fairness", 3, 40);
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int b;
    pat = 4'b1001;
    clear_all();
    chk_en = 1'b1;
    add_beats(1, 32'h10, 4, 1'b1);
    expect_beats(1, 32'h10, 4, 1'b1);
    drive();
    b = 60;
    while (n_out < 4 && b > 0) begin
      m_ready = pat[3 - (cyc % 4)];
      step();
      b--;
    end
    m_ready = 1'b1;
    run_until("backpressure", 4, 10);
    total++;
    if (stalls == 0) begin
      bad++;
      $display("FAIL backpressure_stall_seen: got %0d stalled cycles, required > 0", stalls);
    end
  endtask

  task automatic test_source_gap();
    clear_all();
    chk_en = 1'b1;
    m_ready = 1'b1;
    add_beats(0, 32'h50, 2, 1'b0);
    add_beats(1, 32'h60, 1, 1'b1);
    expect_beats(0, 32'h50, 2, 1'b0);
    expect_beats(0, 32'h52, 1, 1'b1);
    expect_beats(1, 32'h60, 1, 1'b1);
    drive();
    wait_src("source_gap", 0, 2);
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (s_tready[1] !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL gap_hold[%0d]: got ready1=%b busy=%b, required 0/1", c, s_tready[1], busy);
      end
    end
    add_beats(0, 32'h52, 1, 1'b1);
    drive();
    run_until("source_gap", 4, 40);
  endtask

  task automatic test_reset_mid_packet();
    clear_all();
    chk_en = 1'b0;
    m_ready = 1'b1;
    add_beats(2, 32'h90, 4, 1'b1);
    drive();
    wait_src("reset_mid", 2, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_all();
    add_beats(0, 32'h70, 2, 1'b1);
    add_beats(2, 32'h80, 2, 1'b1);
    expect_beats(0, 32'h70, 2, 1'b1);
    expect_beats(2, 32'h80, 2, 1'b1);
    drive();
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_tready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid_clear: got valid=%b busy=%b ready=%b, required 0/0/0000",
               m_valid, busy, s_tready);
    end
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    run_until("reset_mid", 4, 40);
  endtask

  initial begin
    reset = 1'b1;
    m_ready = 1'b1;
    s_tvalid = '0;
    s_tdata = '0;
    s_tlast = '0;
    chk_en = 1'b0;
    test_reset();
    test_all_inputs();
    test_fairness();
    test_backpressure();
    test_source_gap();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- N-input AXI-Stream arbiter that shares one downstream AXI-S path (typically a register slice feeding a shared consumer) between several packet sources.
- Round-robin grant at packet granularity: once granted, an input owns the output until its tlast beat is accepted.
- Output is registered, which breaks the timing path into the shared consumer.

Parameters:
- NUM_INPUTS, 4, number of requesting AXI-S slave ports; legal range 2..16.
- DATA_WIDTH, 32, tdata width per port.
- SEL_WIDTH, $clog2(NUM_INPUTS), grant index width; derived, not overridden.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  NUM_INPUTS  per-input valid; bit i belongs to input i.
- s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  flattened data; input i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tlast  in  NUM_INPUTS  per-input end-of-packet.
- s_axis_tready  out  NUM_INPUTS  per-input ready.
- m_axis_tvalid  out  1  output valid (registered).
- m_axis_tdata  out  DATA_WIDTH  output data (registered).
- m_axis_tlast  out  1  output end-of-packet (registered).
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while a grant is held (state BUSY).

Behaviour:
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - s_axis_tready=all 0, busy=0.
  - state=IDLE, grant=0, last_grant=NUM_INPUTS-1, so input 0 has first priority after reset.
- Output register:
  - load_en = ~m_axis_tvalid | m_axis_tready.
  - Beat accepted from input i when s_axis_tvalid[i] & s_axis_tready[i]; on acceptance, tdata/tlast are loaded and m_axis_tvalid<=1.
  - When load_en is true and no beat is accepted, m_axis_tvalid<=0.
  - Data and tlast are held while m_axis_tvalid & ~m_axis_tready.
  - Latency is 1 cycle from input acceptance to m_axis_tvalid.
- Ready:
  - s_axis_tready[i] = (state==BUSY) & (grant==i) & load_en. Combinational from m_axis_tready.
  - All other bits are 0.
  - Sustains 1 beat/cycle inside a packet.
- FSM:
  - IDLE: no ready asserted. If any s_axis_tvalid bit is set, the winner is the first set bit scanning from (last_grant+1) mod NUM_INPUTS upward with wrap. Then grant<=winner and go to BUSY. This costs a 1-cycle arbitration bubble per packet.
  - BUSY: pass beats from the granted input. When an accepted beat has tlast=1, set last_grant<=grant and go to IDLE. Stay in BUSY otherwise, including while the granted tvalid is low mid-packet; there is no preemption.
  - Illegal state encodings return to IDLE.
- Boundaries:
  - Single-beat packet (tlast on the first beat): grant is released after that beat.
  - Requester deasserting tvalid while in IDLE: the grant decision uses the tvalid value on the deciding cycle only.
  - Ungranted inputs never see ready, even if their tvalid is high in the same cycle as the granted beat.
  - All inputs requesting continuously: strict rotation 0,1,2,3,0...
  - Only one input requesting: it wins every arbitration, with a 1-cycle bubble between packets.
  - Downstream stall: the granted input sees ready=0 while the output is full and stalled; no beat is lost or duplicated.
  - Reset mid-packet: the partial packet is dropped at the output, the grant is cleared, and arbitration restarts from input 0.
  - last_grant and grant never exceed NUM_INPUTS-1 when NUM_INPUTS is not a power of two; wrap uses explicit compare, not bit truncation.

Optional Feature:
- Macro: AXIS_RR_ARBITER_TID_EN.
- When defined:
  - Adds output port m_axis_tid (SEL_WIDTH bits), registered alongside tdata, carrying the source input index of each beat. Reset value is 0.
  - Held under stall, exactly like tdata.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: all s_axis_tvalid=0 for 10 cycles -> m_axis_tvalid=0, s_axis_tready=0000, busy=0 throughout.
- Inputs 0..3 each present one 3-beat packet simultaneously (data 0xA0..0xA2, 0xB0..0xB2, 0xC0.., 0xD0..), m_axis_tready=1 -> output order A, B, C, D. Packets never interleave. One idle cycle separates packets. Each tlast lands on the 3rd beat.
- Round-robin fairness: input 2 wins a packet, then inputs 1 and 3 both request -> input 3 granted before input 1.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat packet 0x10..0x13 from input 1 -> output sequence is exactly 0x10,0x11,0x12,0x13. The beat is held stable while stalled, and s_axis_tready[1]=0 during stalled cycles.
- Mid-packet source gap: input 0 sends 2 beats, drops tvalid for 3 cycles, then sends the tlast beat while input 1 requests -> input 1 not granted until input 0's tlast is accepted.
- Reset asserted during the 2nd beat of a packet -> next cycle m_axis_tvalid=0 and busy=0. With inputs 0 and 2 requesting, input 0 is granted first; with AXIS_RR_ARBITER_TID_EN, m_axis_tid=0 for its beats.
